aes_mix_columns_iter: RTL and testbench
=======================================

# aes_mix_columns_iter

Iterative forward AES MixColumns engine for the encryption datapath. It is the counterpart of the decryption-side InvMixColumns logic. It accepts one 128-bit AES state over a valid/ready handshake and processes one 32-bit column per clock, four clocks per state. It then holds the transformed state until the downstream round logic accepts it.

## Interface
- Parameters: none. All widths are fixed by AES-128.
- `clk  input  1`: system clock; all state changes on posedge.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `in_valid_i  input  1`: `state_i` holds a valid block.
- `in_ready_o  output  1`: engine can accept a block.
- `state_i  input  [0:127]`: input state.
  - Byte k is `state_i[8k:8k+7]`.
  - Column c is bytes 4c..4c+3, with row 0 first (FIPS-197 column-major order).
- `out_valid_o  output  1`: `state_o` holds a completed block.
- `out_ready_i  input  1`: downstream accepts `state_o`.
- `state_o  output  [0:127]`: MixColumns(`state_i`), same byte order.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready_o` = 1. On `in_valid_i` & `in_ready_o`: capture `state_i` into the input register, clear the column counter, go to BUSY.
  - BUSY: each cycle computes column `col_cnt` combinationally from the input register and writes it into bytes 4·`col_cnt`..+3 of the result register. `col_cnt` increments. Once column 3 is written, go to DONE.
  - DONE: `out_valid_o` = 1. `state_o` stays stable until `out_ready_i` = 1, then go to IDLE.
- Column math is over GF(2^8) with polynomial 0x11b. For input column a0..a3:
  - r0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - r1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - r2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - r3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
- GF(2^8) multiply rules:
  - 2·x = {x[1:7],0} ^ (x[0] ? 0x1b : 0x00), where x[0] is the MSB.
  - 3·x = 2·x ^ x.
- `col_cnt` is 2 bits. It must not wrap back into BUSY: the transition out of BUSY is decoded on `col_cnt` == 3.
- `in_valid_i` is ignored outside IDLE. `state_i` need not stay stable after the accept cycle.
- `out_ready_i` is ignored outside DONE.
- `in_ready_o` is 0 in BUSY and DONE. There is no overlap of blocks.

## Timing
- Reset values, asynchronous on `rst_n` low:
  - FSM = IDLE, `col_cnt` = 0.
  - Input and result registers = 0.
  - `in_ready_o` = 1, `out_valid_o` = 0, `state_o` = 0.
- Reset mid-operation: the in-flight block is discarded. No partial output is presented.
- Latency:
  - Accept on edge E. Columns 0..3 are written on edges E+1..E+4.
  - `out_valid_o` is high from just after E+4.
  - Output handshake completes on the first edge with `out_ready_i` = 1. `in_ready_o` is high from the following cycle.
- Throughput: one block per 6 clocks when `out_ready_i` is tied high.
- `state_o` and `out_valid_o` come directly from registers, with no combinational path from inputs.
- `in_ready_o` is decoded from FSM state only.

## Structure
- Shared package `aes_pkg` holds:
  - the GF(2^8) reduction constant 0x1b;
  - `NB` = 4 columns;
  - `BLOCK_W` = 128, `COL_W` = 32;
  - the FSM state enum (IDLE/BUSY/DONE).
- One combinational sub-module, `aes_mix_column`: 32-bit column in, 32-bit column out. It contains the 2·x / 3·x logic and is instantiated once inside the engine.
- Top level holds the FSM, column counter, input register, result register and the byte-lane write enables.

## Test plan
- FIPS-197 columns, each fed as column 0 of an otherwise-zero state; check column 0 of the output:
  - db135345 -> 8e4da1bc
  - f20a225c -> 9fdc589d
  - d4d4d4d5 -> d5d5d7d6
  - 2d26314c -> 4d7ebdf8
- Full round-1 vector:
  - Input d4bf5d30e0b452aeb84111f11e2798e5 -> output 046681e5e0cb199a48f8d37a2806264c.
  - `out_valid_o` rises exactly 4 clocks after the accept edge.
- Fixed points: all-01 and all-c6 states come out unchanged. An all-zero state gives all-zero output.
- Backpressure:
  - Hold `out_ready_i` = 0 for 10 cycles in DONE. `state_o` and `out_valid_o` stay stable and `in_ready_o` stays 0.
  - Pulse `in_valid_i` with a different block during this time; it is not captured.
- Reset mid-operation: deassert `rst_n` asynchronously (between edges) on the second BUSY cycle.
  - Outputs go to reset values immediately.
  - After release, a fresh block processes correctly.
  - No `out_valid_o` is raised for the aborted block.
- Back-to-back: 3 blocks with `in_valid_i` and `out_ready_i` held high. Expect 3 correct outputs at 6-clock spacing, in order.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block and column widths, GF(2^8) reduction constant,
// engine FSM states and the xtime helper.
package aes_pkg;

    localparam int         NB      = 4;
    localparam int         BLOCK_W = 128;
    localparam int         COL_W   = 32;
    localparam logic [7:0] GF_RED  = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by 2 in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_RED : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational MixColumns of one 32-bit column, row 0 in the leftmost byte.
module aes_mix_column
    import aes_pkg::*;
(
    input  logic [0:COL_W-1] column,
    output logic [0:COL_W-1] mixed
);

    logic [7:0] a [NB];
    logic [7:0] d [NB];

    for (genvar r = 0; r < NB; r++) begin : g_byte
        assign a[r] = column[8*r +: 8];
        assign d[r] = xtime(a[r]);
    end

    // 3*x is folded in as 2*x ^ x.
    assign mixed = {
        d[0] ^ d[1] ^ a[1] ^ a[2] ^ a[3],
        a[0] ^ d[1] ^ d[2] ^ a[2] ^ a[3],
        a[0] ^ a[1] ^ d[2] ^ d[3] ^ a[3],
        d[0] ^ a[0] ^ a[1] ^ a[2] ^ d[3]
    };

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative forward MixColumns: accepts a 128-bit state, transforms one column
// per clock, then holds the result until downstream accepts it.
module aes_mix_columns_iter
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [0:BLOCK_W-1] state_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [0:BLOCK_W-1] state_o
);

    state_t             state;
    logic [1:0]         col_cnt;
    logic [0:BLOCK_W-1] in_reg;
    logic [0:BLOCK_W-1] res_reg;
    logic [0:COL_W-1]   col_cur;
    logic [0:COL_W-1]   col_mixed;
    logic [NB*4-1:0]    lane_we;
    logic               out_valid;

    assign col_cur = in_reg[{col_cnt, 5'd0} +: COL_W];

    aes_mix_column u_mix (
        .column (col_cur),
        .mixed  (col_mixed)
    );

    // Byte lane k of the result register is byte k of the state.
    always_comb begin
        lane_we = '0;
        if (state == BUSY) begin
            lane_we[{col_cnt, 2'b00} +: 4] = 4'hf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col_cnt   <= 2'd0;
            in_reg    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        in_reg  <= state_i;
                        col_cnt <= 2'd0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    col_cnt <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_reg <= '0;
        end else begin
            for (int k = 0; k < NB*4; k++) begin
                if (lane_we[k]) begin
                    res_reg[8*k +: 8] <= col_mixed[8*(k % 4) +: 8];
                end
            end
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = out_valid;
    assign state_o     = res_reg;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Self-checking bench for aes_mix_columns_iter against a generic GF(2^8) matrix model.
module tb_aes_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [0:127] state_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [0:127] state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_mix_columns_iter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .state_i     (state_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .state_o     (state_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Shift-and-add multiply in GF(2^8) with polynomial 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // MixColumns as a circulant matrix product, column-major byte order.
    function automatic logic [0:127] mix_ref(input logic [0:127] s);
        logic [7:0]   base [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [0:127] o;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(base[(k - r + 4) % 4], s[8*(4*c+k) +: 8]);
                o[8*(4*c+r) +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Push one block and retire it; returns the observed output.
    task automatic run_block(input string tag, input logic [0:127] blk, output logic [0:127] got);
        int cyc;
        int w;
        w = 0;
        while (!in_ready_o && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check({tag, "_ready"}, 128'(in_ready_o), 128'(1));
        in_valid_i = 1'b1;
        state_i    = blk;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        state_i    = rand_block();
        cyc = 0;
        while (!out_valid_o && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, "_lat"}, 128'(cyc), 128'(4));
        got = state_o;
        check({tag, "_data"}, got, mix_ref(blk));
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        check({tag, "_vld_clr"}, 128'(out_valid_o), 128'(0));
        check({tag, "_rdy_back"}, 128'(in_ready_o), 128'(1));
    endtask

    initial begin
        logic [0:127] got, held, blk, col0;
        logic [0:127] bb_in [3];
        logic [0:127] fips_in  [4];
        logic [31:0]  fips_out [4];
        int out_idx, in_idx, last_out_cyc, cyc, stray;
        bit acc;

        fips_in[0] = {32'hdb135345, 96'h0}; fips_out[0] = 32'h8e4da1bc;
        fips_in[1] = {32'hf20a225c, 96'h0}; fips_out[1] = 32'h9fdc589d;
        fips_in[2] = {32'hd4d4d4d5, 96'h0}; fips_out[2] = 32'hd5d5d7d6;
        fips_in[3] = {32'h2d26314c, 96'h0}; fips_out[3] = 32'h4d7ebdf8;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready_o), 128'(1));
        check("rst_out_valid", 128'(out_valid_o), 128'(0));
        check("rst_state_o", state_o, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            run_block($sformatf("fips%0d", i), fips_in[i], got);
            col0 = got;
            check($sformatf("fips%0d_col0", i), 128'(col0[0:31]), 128'(fips_out[i]));
        end

        run_block("round1", 128'hd4bf5d30e0b452aeb84111f11e2798e5, got);
        check("round1_vec", got, 128'h046681e5e0cb199a48f8d37a2806264c);

        run_block("fix01", {16{8'h01}}, got);
        check("fix01_same", got, {16{8'h01}});
        run_block("fixc6", {16{8'hc6}}, got);
        check("fixc6_same", got, {16{8'hc6}});
        run_block("zero", 128'h0, got);
        check("zero_same", got, 128'h0);

        // Backpressure with an intruding block offered while DONE.
        blk = rand_block();
        in_valid_i = 1'b1;
        state_i    = blk;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_valid", 128'(out_valid_o), 128'(1));
        held = state_o;
        check("bp_data", held, mix_ref(blk));
        for (int i = 0; i < 10; i++) begin
            in_valid_i = (i % 3 == 0);
            state_i    = rand_block();
            @(posedge clk); #1;
            check("bp_hold_data", state_o, held);
            check("bp_hold_valid", 128'(out_valid_o), 128'(1));
            check("bp_hold_ready", 128'(in_ready_o), 128'(0));
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        check("bp_release_vld", 128'(out_valid_o), 128'(0));
        check("bp_release_rdy", 128'(in_ready_o), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_capture", 128'(out_valid_o), 128'(0));

        // Asynchronous reset during the second BUSY cycle.
        in_valid_i = 1'b1;
        state_i    = rand_block();
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 128'(in_ready_o), 128'(1));
        check("mid_rst_valid", 128'(out_valid_o), 128'(0));
        check("mid_rst_data", state_o, 128'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid_o) stray++;
        end
        check("mid_rst_no_out", 128'(stray), 128'(0));
        run_block("post_rst", rand_block(), got);

        for (int i = 0; i < 8; i++)
            run_block($sformatf("rand%0d", i), rand_block(), got);

        // Back-to-back with both handshakes held high.
        for (int i = 0; i < 3; i++) bb_in[i] = rand_block();
        out_ready_i  = 1'b1;
        in_valid_i   = 1'b1;
        state_i      = bb_in[0];
        in_idx       = 0;
        out_idx      = 0;
        last_out_cyc = -1;
        cyc          = 0;
        while (out_idx < 3 && cyc < 60) begin
            acc = in_ready_o && in_valid_i;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                in_idx++;
                if (in_idx < 3) state_i = bb_in[in_idx];
                else in_valid_i = 1'b0;
            end
            if (out_valid_o) begin
                check($sformatf("b2b%0d_data", out_idx), state_o, mix_ref(bb_in[out_idx]));
                if (last_out_cyc >= 0)
                    check($sformatf("b2b%0d_gap", out_idx), 128'(cyc - last_out_cyc), 128'(6));
                last_out_cyc = cyc;
                out_idx++;
            end
        end
        check("b2b_count", 128'(out_idx), 128'(3));
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
